axi_4_lite_regfile_slv: RTL and testbench
=========================================

AXI_4_LITE_REGFILE_SLV -- requirements
Module: axi_4_lite_regfile_slv

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 8, byte address width.
REQ-003 SHALL have parameter C_NUM_REGS, default 32, register count; power of two, 2..256.
REQ-004 SHALL have parameter C_RO_MASK, default 0, C_NUM_REGS-bit mask; bit i=1 makes register i read-only from AXI.
REQ-005 SHALL have ports, in order (clock and reset first):
  S_AXI_ACLK  in  1  clock; all state changes on rising edge.
  S_AXI_ARESET  in  1  reset; asynchronous, active-high.
  S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake.
  S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write byte address.
  S_AXI_AWPROT  in  3  ignored.
  S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake.
  S_AXI_WDATA  in  C_AXI_DATA_WIDTH  write data.
  S_AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte strobes.
  S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake.
  S_AXI_BRESP  out  2  OKAY=00, SLVERR=10.
  S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake.
  S_AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read byte address.
  S_AXI_ARPROT  in  3  ignored.
  S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake.
  S_AXI_RDATA  out  C_AXI_DATA_WIDTH  read data.
  S_AXI_RRESP  out  2  read response.
  HW_RO_DATA  in  C_NUM_REGS*C_AXI_DATA_WIDTH  flattened values returned for read-only registers.
  REG_WR_PULSE  out  C_NUM_REGS  one-cycle pulse, bit i = register i committed.
  DEB_READ_INDEX/DEB_WRITE_INDEX  out  log2(C_NUM_REGS)  last decoded read/write index.

Function
REQ-006 SHALL decode index = addr[LSB +: log2(C_NUM_REGS)], LSB = log2(C_AXI_DATA_WIDTH/8); low LSB bits ignored.
REQ-007 SHALL flag an address out-of-range when any addr bit above the index field is 1.
REQ-008 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-009 SHALL drive AWREADY=1 only in W_IDLE and W_HAVE_DATA; WREADY=1 only in W_IDLE and W_HAVE_ADDR.
REQ-010 W_IDLE: AW-only handshake latches address -> W_HAVE_ADDR; W-only latches data/strobe -> W_HAVE_DATA; both in same cycle -> commit -> W_RESP.
REQ-011 W_HAVE_ADDR on W handshake, or W_HAVE_DATA on AW handshake, SHALL commit -> W_RESP.
REQ-012 Commit SHALL update only bytes with WSTRB=1 of a writable, in-range register at the committing edge; BRESP=OKAY.
REQ-013 Commit to a read-only or out-of-range address SHALL leave all registers unchanged; BRESP=SLVERR; no REG_WR_PULSE.
REQ-014 REG_WR_PULSE bit SHALL be high exactly the one cycle after a successful commit, including WSTRB=0.
REQ-015 W_RESP SHALL hold BVALID=1 and BRESP stable until BREADY=1, then -> W_IDLE; BVALID asserts the cycle after commit.
REQ-016 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_RESP (RVALID=1, ARREADY=0).
REQ-017 AR handshake SHALL register RDATA/RRESP and enter R_RESP; RVALID visible the cycle after handshake.
REQ-018 RDATA SHALL be the register value (writable), HW_RO_DATA slice (read-only) or 0 with RRESP=SLVERR (out-of-range).
REQ-019 RDATA/RRESP SHALL stay stable while RVALID=1 and RREADY=0; RVALID&RREADY -> R_IDLE.
REQ-020 Read and write FSMs SHALL operate independently; a read of a register committed on the same edge returns the pre-write value.
REQ-021 DEB_WRITE_INDEX SHALL update on commit; DEB_READ_INDEX on AR handshake.

Reset
REQ-022 S_AXI_ARESET=1 SHALL immediately clear all registers to 0, both FSMs to idle, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, REG_WR_PULSE=0, debug indices=0.
REQ-023 While reset is high AWREADY, WREADY and ARREADY SHALL be 0; reset mid-transaction discards that transaction with no response.

Verification
REQ-024 AW+W same cycle, addr 0x00, 0xDEADBEEF, WSTRB 1111 -> BRESP OKAY; read 0x00 returns 0xDEADBEEF.
REQ-025 Reg 5 preloaded 0xFFFFFFFF, write 0x00563400 with WSTRB 0110 -> read 0x14 returns 0xFF5634FF.
REQ-026 W two cycles before AW to reg 31 with 0xA5A5A5A5 -> single commit, REG_WR_PULSE[31] one cycle, read 0x7C returns 0xA5A5A5A5.
REQ-027 C_RO_MASK bit 3 set, HW_RO_DATA slice 3=0x12345678: write 0x0C -> SLVERR, read 0x0C -> 0x12345678 OKAY; read 0x80 -> 0, SLVERR.
REQ-028 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable, no new AW/W/AR accepted.
REQ-029 Assert reset during W_HAVE_ADDR and R_RESP -> all valids 0 same cycle; post-reset read 0x00 returns 0.

Source files
------------

// File: rtl/axi_4_lite_regfile_slv.sv
// AXI4-Lite slave register file. Writable registers live in a flop array;
// registers flagged in C_RO_MASK return HW_RO_DATA instead and reject writes.
// Write and read channels run as independent FSMs.
module axi_4_lite_regfile_slv #(
    parameter int                     C_AXI_DATA_WIDTH = 32,
    parameter int                     C_AXI_ADDR_WIDTH = 8,
    parameter int                     C_NUM_REGS       = 32,
    parameter logic [C_NUM_REGS-1:0]  C_RO_MASK        = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    output logic [1:0]                             S_AXI_BRESP,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    input  logic [C_NUM_REGS*C_AXI_DATA_WIDTH-1:0] HW_RO_DATA,
    output logic [C_NUM_REGS-1:0]                  REG_WR_PULSE,
    output logic [$clog2(C_NUM_REGS)-1:0]          DEB_READ_INDEX,
    output logic [$clog2(C_NUM_REGS)-1:0]          DEB_WRITE_INDEX
);
    localparam int DW  = C_AXI_DATA_WIDTH;
    localparam int AW  = C_AXI_ADDR_WIDTH;
    localparam int SW  = DW / 8;
    localparam int IW  = $clog2(C_NUM_REGS);
    localparam int LSB = $clog2(SW);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic [DW-1:0]     regs_q [C_NUM_REGS];
    logic [DW-1:0]     regs_d [C_NUM_REGS];
    logic [DW-1:0]     ro_data [C_NUM_REGS];
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [C_NUM_REGS-1:0] pulse_q, pulse_d;
    logic [IW-1:0]     deb_r_q, deb_r_d, deb_w_q, deb_w_d;

    logic              aw_hs, w_hs, ar_hs, commit, wr_ok, wr_oor, rd_oor;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_strb;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic              unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Unpack the flattened read-only value bus into one word per register.
    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_ro
            assign ro_data[gi] = HW_RO_DATA[gi*DW +: DW];
        end
    endgenerate

    // Readies decode from state and are forced low while reset is held.
    assign S_AXI_AWREADY = !S_AXI_ARESET && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
    assign S_AXI_WREADY  = !S_AXI_ARESET && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
    assign S_AXI_ARREADY = !S_AXI_ARESET && (r_state_q == R_IDLE);
    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write channel: collect address and data in either order, then commit once.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        deb_w_d   = deb_w_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        commit    = 1'b0;
        wr_addr   = S_AXI_AWADDR;
        wr_data   = S_AXI_WDATA;
        wr_strb   = S_AXI_WSTRB;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    awaddr_d  = S_AXI_AWADDR;
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d   = S_AXI_WDATA;
                    wstrb_d   = S_AXI_WSTRB;
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                wr_addr = awaddr_q;
                commit  = w_hs;
            end
            W_HAVE_DATA: begin
                wr_data = wdata_q;
                wr_strb = wstrb_q;
                commit  = aw_hs;
            end
            default: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
        endcase
        // Any address bit above the index field puts the access out of range.
        wr_idx = wr_addr[LSB +: IW];
        wr_oor = (wr_addr >> (LSB + IW)) != '0;
        wr_ok  = !wr_oor && !C_RO_MASK[wr_idx];
        if (commit) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            deb_w_d   = wr_idx;
            if (wr_ok) begin
                pulse_d[wr_idx] = 1'b1;
                for (int b = 0; b < SW; b++) begin
                    if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read channel: capture the response on handshake and hold it until RREADY.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        deb_r_d   = deb_r_q;
        rd_idx    = S_AXI_ARADDR[LSB +: IW];
        rd_oor    = (S_AXI_ARADDR >> (LSB + IW)) != '0;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) begin
                r_state_d = R_RESP;
                rvalid_d  = 1'b1;
                deb_r_d   = rd_idx;
                rresp_d   = rd_oor ? RESP_SLVERR : RESP_OKAY;
                if (rd_oor)                 rdata_d = '0;
                else if (C_RO_MASK[rd_idx]) rdata_d = ro_data[rd_idx];
                else                        rdata_d = regs_q[rd_idx];
            end
        end else if (S_AXI_RREADY) begin
            rvalid_d  = 1'b0;
            r_state_d = R_IDLE;
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            regs_q    <= '{default: '0};
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            pulse_q   <= '0;
            deb_r_q   <= '0;
            deb_w_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            regs_q    <= regs_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            deb_r_q   <= deb_r_d;
            deb_w_q   <= deb_w_d;
        end
    end

    assign S_AXI_BVALID    = bvalid_q;
    assign S_AXI_BRESP     = bresp_q;
    assign S_AXI_RVALID    = rvalid_q;
    assign S_AXI_RRESP     = rresp_q;
    assign S_AXI_RDATA     = rdata_q;
    assign REG_WR_PULSE    = pulse_q;
    assign DEB_READ_INDEX  = deb_r_q;
    assign DEB_WRITE_INDEX = deb_w_q;
endmodule

// File: tb/tb_axi_4_lite_regfile_slv.sv
// Directed bench for the AXI4-Lite register file with a response scoreboard.
module tb_axi_4_lite_regfile_slv;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic        clk = 1'b0, rst = 1'b1;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [7:0]  awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, pulse;
    logic [4:0]  deb_r, deb_w;
    logic [1023:0] hw_ro;

    int errors = 0, checks = 0;
    logic [1:0]  bq[$];
    logic [31:0] rdq[$];
    logic [1:0]  rrq[$];

    always #5 clk = ~clk;

    axi_4_lite_regfile_slv #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8), .C_NUM_REGS(32),
                             .C_RO_MASK(32'h0000_0008)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .HW_RO_DATA(hw_ro), .REG_WR_PULSE(pulse),
        .DEB_READ_INDEX(deb_r), .DEB_WRITE_INDEX(deb_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drive until every asserted AW/W valid has been accepted.
    task automatic hs_write();
        logic aw_acc, w_acc;
        for (int n = 0; n < 50 && (awvalid || wvalid); n++) begin
            @(negedge clk);
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            tick();
            if (aw_acc) awvalid = 0;
            if (w_acc)  wvalid = 0;
        end
        if (awvalid || wvalid) begin
            chk("write_hs_timeout", 0, 1);
            awvalid = 0; wvalid = 0;
        end
    endtask

    task automatic wait_b(input int hold);
        logic found = 0;
        for (int h = 0; h < hold; h++) begin
            awvalid = 1; awaddr = 8'h00; wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
            @(negedge clk);
            chk("hold_bvalid", bvalid, 1);
            chk("hold_bresp", bresp, bq[0]);
            chk("hold_no_aw", awready, 0);
            chk("hold_no_w", wready, 0);
            tick();
            awvalid = 0; wvalid = 0;
            chk("hold_no_pulse", pulse, 0);
        end
        bready = 1;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (bvalid) found = 1; else tick();
        end
        if (!found) chk("bvalid_timeout", 0, 1);
        else chk("bresp", bresp, bq.pop_front());
        tick();
        bready = 0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first; exp_idx < 0 means no pulse.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int order, input int gap, input logic [1:0] exp_resp,
                             input int exp_idx, input int hold);
        logic [31:0] exp_pulse = (exp_idx < 0) ? 32'h0 : (32'h1 << exp_idx);
        bq.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = (order != 2); wvalid = (order != 1);
        hs_write();
        if (order != 0) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (order == 1) chk("wait_no_aw", awready, 0);
                else            chk("wait_no_w", wready, 0);
                chk("wait_no_bvalid", bvalid, 0);
                chk("wait_no_pulse", pulse, 0);
                tick();
            end
            awaddr = addr; wdata = data; wstrb = strb;
            if (order == 1) wvalid = 1; else awvalid = 1;
            hs_write();
        end
        chk("bvalid_after_commit", bvalid, 1);
        chk("wr_pulse", pulse, exp_pulse);
        chk("deb_write_index", deb_w, addr[6:2]);
        tick();
        chk("wr_pulse_one_cycle", pulse, 0);
        wait_b(hold);
    endtask

    task automatic wait_r(input int hold);
        logic found = 0;
        for (int h = 0; h < hold; h++) begin
            arvalid = 1; araddr = 8'h04;
            @(negedge clk);
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, rdq[0]);
            chk("hold_rresp", rresp, rrq[0]);
            chk("hold_no_ar", arready, 0);
            tick();
            arvalid = 0;
        end
        rready = 1;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (rvalid) found = 1; else tick();
        end
        if (!found) chk("rvalid_timeout", 0, 1);
        else begin
            chk("rdata", rdata, rdq.pop_front());
            chk("rresp", rresp, rrq.pop_front());
        end
        tick();
        rready = 0;
        chk("rvalid_drop", rvalid, 0);
    endtask

    task automatic issue_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic acc = 0;
        rdq.push_back(exp_data); rrq.push_back(exp_resp);
        araddr = addr; arvalid = 1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = arready;
            tick();
        end
        arvalid = 0;
        if (!acc) chk("ar_timeout", 0, 1);
        chk("rvalid_after_ar", rvalid, 1);
        chk("deb_read_index", deb_r, addr[6:2]);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input int hold);
        issue_read(addr, exp_data, exp_resp);
        wait_r(hold);
    endtask

    initial begin
        hw_ro = '0;
        hw_ro[3*32 +: 32] = 32'h1234_5678;
        hw_ro[0 +: 32]    = 32'hBAD0_BAD0;

        // Reset state
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulse", pulse, 0);
        chk("rst_deb", {deb_r, deb_w}, 0);
        repeat (3) tick();
        rst = 0;
        tick();
        chk("idle_readies", {awready, wready, arready}, 3'b111);

        // Simultaneous AW/W to reg 0
        axi_write(8'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, OKAY, 0, 0);
        axi_read(8'h00, 32'hDEAD_BEEF, OKAY, 0);

        // Byte-strobe merge on reg 5
        axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, OKAY, 5, 0);
        axi_write(8'h14, 32'h0056_3400, 4'b0110, 0, 0, OKAY, 5, 0);
        axi_read(8'h14, 32'hFF56_34FF, OKAY, 0);

        // W two cycles ahead of AW to reg 31
        axi_write(8'h7C, 32'hA5A5_A5A5, 4'hF, 2, 2, OKAY, 31, 0);
        axi_read(8'h7C, 32'hA5A5_A5A5, OKAY, 0);

        // AW ahead of W with no strobes: pulses but leaves data unchanged
        axi_write(8'h08, 32'hFFFF_FFFF, 4'h0, 1, 1, OKAY, 2, 0);
        axi_read(8'h08, 32'h0000_0000, OKAY, 0);

        // Read-only and out-of-range accesses
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, SLVERR, -1, 0);
        axi_read(8'h0C, 32'h1234_5678, OKAY, 0);
        axi_read(8'h80, 32'h0000_0000, SLVERR, 0);
        axi_write(8'h84, 32'h7777_7777, 4'hF, 0, 0, SLVERR, -1, 0);
        axi_read(8'h04, 32'h0000_0000, OKAY, 0);

        // Back-pressure on both response channels
        axi_write(8'h18, 32'hCAFE_F00D, 4'hF, 0, 0, OKAY, 6, 5);
        axi_read(8'h18, 32'hCAFE_F00D, OKAY, 5);
        axi_read(8'h00, 32'hDEAD_BEEF, OKAY, 0);

        // Read and write of the same register on one edge sees the old value
        axi_write(8'h10, 32'h1111_1111, 4'hF, 0, 0, OKAY, 4, 0);
        bq.push_back(OKAY);
        rdq.push_back(32'h1111_1111); rrq.push_back(OKAY);
        awaddr = 8'h10; wdata = 32'h2222_2222; wstrb = 4'hF; araddr = 8'h10;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        chk("same_edge_readies", {awready, wready, arready}, 3'b111);
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("same_edge_valids", {bvalid, rvalid}, 2'b11);
        wait_b(0);
        wait_r(0);
        axi_read(8'h10, 32'h2222_2222, OKAY, 0);

        // Reset during W_HAVE_ADDR and R_RESP
        awaddr = 8'h00; awvalid = 1;
        hs_write();
        issue_read(8'h00, 32'hDEAD_BEEF, OKAY);
        chk("pre_rst_rdata", rdata, 32'hDEAD_BEEF);
        #3 rst = 1;
        #1;
        chk("mid_rst_valids", {bvalid, rvalid}, 2'b00);
        chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_deb", {deb_r, deb_w}, 0);
        rdq.delete(); rrq.delete(); bq.delete();
        repeat (2) tick();
        rst = 0;
        tick();
        chk("post_rst_idle", {awready, wready, arready, bvalid}, 4'b1110);
        axi_read(8'h00, 32'h0000_0000, OKAY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
